// File: rtl/ysyx_25040101_mdu_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: funct3 codes, FSM states, datapath width.
// Pure declarations: no latency or backpressure behaviour of its own.
package ysyx_25040101_mdu_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] MDU_MUL    = 3'b000;
    localparam logic [2:0] MDU_MULH   = 3'b001;
    localparam logic [2:0] MDU_MULHSU = 3'b010;
    localparam logic [2:0] MDU_MULHU  = 3'b011;
    localparam logic [2:0] MDU_DIV    = 3'b100;
    localparam logic [2:0] MDU_DIVU   = 3'b101;
    localparam logic [2:0] MDU_REM    = 3'b110;
    localparam logic [2:0] MDU_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } mdu_state_t;

endpackage

// File: rtl/ysyx_25040101_mdu_sign.sv
// Operand magnitude/sign decode and result negate; combinational, 0 cycles.
// No handshake: it has no state and cannot apply backpressure.
module ysyx_25040101_mdu_sign
    import ysyx_25040101_mdu_pkg::*;
(
    input  logic [2:0]        op,
    input  logic [XLEN-1:0]   srca,
    input  logic [XLEN-1:0]   srcb,
    output logic [XLEN-1:0]   abs_a,
    output logic [XLEN-1:0]   abs_b,
    output logic              prod_neg,
    output logic              rem_neg,
    input  logic              neg_en,
    input  logic [2*XLEN-1:0] neg_val,
    output logic [2*XLEN-1:0] neg_out
);

    logic a_signed;
    logic b_signed;
    logic sign_a;
    logic sign_b;

    always_comb begin
        a_signed = !(op == MDU_MULHU || op == MDU_DIVU || op == MDU_REMU);
        b_signed = (op == MDU_MUL || op == MDU_MULH || op == MDU_DIV || op == MDU_REM);
        sign_a   = a_signed & srca[XLEN-1];
        sign_b   = b_signed & srcb[XLEN-1];
        // 0x80000000 maps onto itself, which is the correct unsigned magnitude.
        abs_a    = sign_a ? (~srca + 1'b1) : srca;
        abs_b    = sign_b ? (~srcb + 1'b1) : srcb;
        prod_neg = sign_a ^ sign_b;
        rem_neg  = sign_a;
        neg_out  = neg_en ? (~neg_val + 1'b1) : neg_val;
    end

endmodule

// File: rtl/ysyx_25040101_mdu.sv
// Iterative RV32M mul/div: 33 cycles accept-to-result (1 for div-by-zero/overflow).
// in_ready_o only in IDLE; result held in DONE until out_ready_i; flush_i aborts.
module ysyx_25040101_mdu #(
    parameter int XLEN  = 32,
    parameter int ITERS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] srca_data_i,
    input  logic [XLEN-1:0] srcb_data_i,
    input  logic            flush_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] result_o
);

    import ysyx_25040101_mdu_pkg::*;

    localparam logic [5:0] LAST_ITER = 6'(ITERS - 1);

    mdu_state_t state_q, state_d;

    logic [5:0]        cnt_q;
    logic [2:0]        op_q;
    logic              prod_neg_q;
    logic              rem_neg_q;
    logic [XLEN-1:0]   divisor_q;
    logic [2*XLEN-1:0] acc_q;
    logic [XLEN-1:0]   result_q;

    logic [XLEN-1:0]   abs_a;
    logic [XLEN-1:0]   abs_b;
    logic              prod_neg;
    logic              rem_neg;
    logic              fix_neg;
    logic [2*XLEN-1:0] fix_val;
    logic [2*XLEN-1:0] fix_out;

    logic              accept;
    logic              div_zero;
    logic              div_ovf;
    logic              special;
    logic [XLEN-1:0]   special_res;

    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [XLEN:0]     div_shift;
    logic [XLEN:0]     div_diff;
    logic [2*XLEN-1:0] div_next;
    logic [2*XLEN-1:0] acc_next;
    logic [XLEN-1:0]   final_res;

    ysyx_25040101_mdu_sign u_sign (
        .op       (op_i),
        .srca     (srca_data_i),
        .srcb     (srcb_data_i),
        .abs_a    (abs_a),
        .abs_b    (abs_b),
        .prod_neg (prod_neg),
        .rem_neg  (rem_neg),
        .neg_en   (fix_neg),
        .neg_val  (fix_val),
        .neg_out  (fix_out)
    );

    assign accept      = (state_q == IDLE) && in_valid_i;
    assign in_ready_o  = (state_q == IDLE);
    assign out_valid_o = (state_q == DONE);
    assign result_o    = result_q;

    always_comb begin
        div_zero    = (srcb_data_i == '0);
        div_ovf     = (op_i == MDU_DIV || op_i == MDU_REM)
                      && (srca_data_i == {1'b1, {(XLEN-1){1'b0}}})
                      && (srcb_data_i == '1);
        special     = op_i[2] && (div_zero || div_ovf);
        special_res = '0;
        if (div_zero) begin
            special_res = op_i[1] ? srca_data_i : '1;
        end else if (div_ovf) begin
            special_res = op_i[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
        end
    end

    // Multiply: accumulator is {product high, remaining multiplier bits}, shifted right.
    // Divide: accumulator is {partial remainder, dividend bits / quotient bits}, shifted left.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, divisor_q} : '0);
        mul_next  = {mul_sum, acc_q[XLEN-1:1]};
        div_shift = acc_q[2*XLEN-1:XLEN-1];
        div_diff  = div_shift - {1'b0, divisor_q};
        if (div_diff[XLEN]) begin
            div_next = {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        end else begin
            div_next = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        end
        acc_next = op_q[2] ? div_next : mul_next;
    end

    always_comb begin
        fix_val = acc_next;
        fix_neg = prod_neg_q;
        if (op_q == MDU_DIV || op_q == MDU_DIVU) begin
            fix_val = {{XLEN{1'b0}}, acc_next[XLEN-1:0]};
        end else if (op_q == MDU_REM || op_q == MDU_REMU) begin
            fix_val = {{XLEN{1'b0}}, acc_next[2*XLEN-1:XLEN]};
            fix_neg = rem_neg_q;
        end
        final_res = (op_q == MDU_MUL || op_q[2]) ? fix_out[XLEN-1:0]
                                                 : fix_out[2*XLEN-1:XLEN];
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (in_valid_i) state_d = special ? DONE : CALC;
            CALC: if (cnt_q == LAST_ITER) state_d = DONE;
            DONE: if (out_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush_i) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            op_q       <= '0;
            prod_neg_q <= 1'b0;
            rem_neg_q  <= 1'b0;
            divisor_q  <= '0;
            acc_q      <= '0;
            result_q   <= '0;
        end else if (!flush_i) begin
            if (accept) begin
                cnt_q      <= '0;
                op_q       <= op_i;
                prod_neg_q <= prod_neg;
                rem_neg_q  <= rem_neg;
                divisor_q  <= abs_b;
                acc_q      <= {{XLEN{1'b0}}, abs_a};
                if (special) begin
                    result_q <= special_res;
                end
            end else if (state_q == CALC) begin
                cnt_q <= cnt_q + 6'd1;
                acc_q <= acc_next;
                if (cnt_q == LAST_ITER) begin
                    result_q <= final_res;
                end
            end
        end
    end

endmodule

// File: tb/tb_ysyx_25040101_mdu.sv
// Directed-vector bench for the RV32M mul/div unit with a queue scoreboard and a
// monitor that checks result value and accept-to-valid edge count on each new result.
module tb_ysyx_25040101_mdu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  op = 3'd0;
    logic [31:0] srca = 32'd0;
    logic [31:0] srcb = 32'd0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [31:0] exp_q[$];
    int          lat_q[$];
    int          acc_q[$];
    logic        prev_vld = 1'b0;

    ysyx_25040101_mdu #(.XLEN(32), .ITERS(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .op_i        (op),
        .srca_data_i (srca),
        .srcb_data_i (srcb),
        .flush_i     (flush),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .result_o    (result)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    // Monitor: one scoreboard pop per rising edge of out_valid.
    always @(negedge clk) begin
        logic [31:0] e;
        int l;
        int a;
        if (out_valid && !prev_vld) begin
            checks = checks + 1;
            if (exp_q.size() == 0) begin
                errors = errors + 1;
                $display("FAIL unexpected_valid: result=%h with nothing outstanding", result);
            end else begin
                e = exp_q.pop_front();
                l = lat_q.pop_front();
                a = acc_q.pop_front();
                if (result !== e) begin
                    errors = errors + 1;
                    $display("FAIL result: got %h expected %h", result, e);
                end
                checks = checks + 1;
                if (cyc - a != l) begin
                    errors = errors + 1;
                    $display("FAIL latency: got %0d edges expected %0d (result %h)", cyc - a, l, e);
                end
            end
        end
        prev_vld = out_valid;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks = checks + 1;
        if (got !== want) begin
            errors = errors + 1;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    // Present one op; when chk is set, push the expected result and edge latency.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input bit chk, input logic [31:0] e, input int lat);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL issue_timeout: in_ready stayed 0 for op %0d", o);
            return;
        end
        in_valid = 1'b1;
        op = o;
        srca = a;
        srcb = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (chk) begin
            exp_q.push_back(e);
            lat_q.push_back(lat);
            acc_q.push_back(cyc);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL drain_timeout: %0d results still outstanding", exp_q.size());
            exp_q.delete();
            lat_q.delete();
            acc_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    typedef struct {
        logic [2:0]  o;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] e;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    initial begin
        vecs.push_back('{3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 32});
        vecs.push_back('{3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 32});
        vecs.push_back('{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32});
        vecs.push_back('{3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32});
        vecs.push_back('{3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32});
        vecs.push_back('{3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32});
        vecs.push_back('{3'b101, 32'd100,      32'd7,        32'd14,       32});
        vecs.push_back('{3'b111, 32'd100,      32'd7,        32'd2,        32});
        vecs.push_back('{3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 0});
        vecs.push_back('{3'b111, 32'd5,        32'd0,        32'd5,        0});
        vecs.push_back('{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0});
        vecs.push_back('{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        0});

        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_result", result, 32'd0);

        foreach (vecs[i]) begin
            issue(vecs[i].o, vecs[i].a, vecs[i].b, 1'b1, vecs[i].e, vecs[i].lat);
            drain();
        end

        // Backpressure: result must hold while the consumer stalls.
        out_ready = 1'b0;
        issue(3'b101, 32'd100, 32'd7, 1'b1, 32'd14, 32);
        drain();
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("bp_result_stable", result, 32'd14);
            check("bp_state", {30'd0, out_valid, in_ready}, 32'd2);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
        check("bp_release_out_valid", {31'd0, out_valid}, 32'd0);

        // Flush at iteration 15 leaves no result behind.
        issue(3'b000, 32'd1234, 32'd5678, 1'b0, 32'd0, 0);
        repeat (15) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_in_ready", {31'd0, in_ready}, 32'd1);
        check("flush_out_valid", {31'd0, out_valid}, 32'd0);
        repeat (40) @(negedge clk);
        issue(3'b000, 32'd3, 32'd4, 1'b1, 32'd12, 32);
        drain();

        // Reset in mid-calculation.
        issue(3'b100, 32'd1000, 32'd3, 1'b0, 32'd0, 0);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_result", result, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ysyx_25040101_mdu.md
# ysyx_25040101_mdu

Iterative RV32M multiply/divide unit sitting directly downstream of the ALU operand muxes. It consumes `srca_data` and `srcb_data` (the output of the srcb mux: rs2, immediate or constant) for M-extension instructions, computes over multiple cycles, and returns a 32-bit result to writeback through a valid/ready handshake. It runs beside the single-cycle ALU and replaces its result when an M-op is decoded.

## Interface
Parameters
- `XLEN`, 32 — operand/result width. Only 32 is supported.
- `ITERS`, 32 — iterations per multiply/divide. Equals `XLEN`.

Ports
- `clk`  in  1  — the single clock.
- `rst`  in  1  — synchronous, active-high reset.
- `in_valid_i`  in  1  — an operation is presented.
- `in_ready_o`  out  1  — unit can accept. High only in IDLE.
- `op_i`  in  3  — funct3: 000 mul, 001 mulh, 010 mulhsu, 011 mulhu, 100 div, 101 divu, 110 rem, 111 remu.
- `srca_data_i`  in  32  — rs1 operand.
- `srcb_data_i`  in  32  — operand from the srcb mux.
- `flush_i`  in  1  — abort any operation in flight.
- `out_valid_o`  out  1  — `result_o` is valid.
- `out_ready_i`  in  1  — consumer takes the result.
- `result_o`  out  32  — result.

## Operation
- FSM states: IDLE, CALC, DONE.
- **IDLE**
  - `in_valid_i & in_ready_o` at a rising edge is "accept".
  - Accept latches op, absolute operand magnitudes and result sign flags.
  - Clears the 6-bit iteration counter.
  - A special-case op goes straight to DONE; every other op goes to CALC.
- **Special cases**, resolved at accept and placed in the result register directly:
  - Divide by zero (srcb == 0): div/divu → 0xFFFFFFFF; rem/remu → srca.
  - Signed overflow (div/rem, srca == 0x80000000, srcb == 0xFFFFFFFF): div → 0x80000000; rem → 0.
- **CALC, multiply**
  - Radix-2 shift-add over a 64-bit accumulator of |a|·|b|.
  - Sign handling: mul/mulh treat both operands as signed; mulhsu treats a as signed, b as unsigned; mulhu treats both as unsigned.
  - Final two's-complement negate when the sign flags differ.
  - mul returns bits [31:0]; mulh, mulhsu and mulhu return bits [63:32].
- **CALC, divide**
  - Restoring divide with a 33-bit partial remainder.
  - Each iteration: shift in the next dividend bit, trial-subtract, and set a quotient bit when the result is non-negative.
  - Sign fixup (div, rem only): quotient negated when the operand signs differ; remainder takes the dividend's sign.
- **Counter:** increments once per CALC cycle. After iteration `ITERS-1` the fixed-up result is registered and the state moves to DONE.
- **DONE**
  - `out_valid_o` = 1 and `result_o` stays stable until `out_ready_i` is seen high at an edge; the state then returns to IDLE.
  - Inputs arriving in DONE are ignored, because `in_ready_o` is 0.
- **`flush_i`**
  - Forces IDLE at the next edge from any state.
  - Drops `out_valid_o` and discards the operation.
  - Priority: `rst` > `flush_i` > handshake.
- **Arithmetic:** all of it is modulo 2^32 / 2^64 with no saturation or exceptions.

## Timing
- **Reset values:** state IDLE, `in_ready_o` = 1, `out_valid_o` = 0, `result_o` = 0, counter = 0. Reset in mid-CALC abandons the operation.
- **Normal op:** accept at edge E0. `out_valid_o` rises after edge E32, i.e. 33 cycles from accept to result.
- **Special case:** `out_valid_o` rises after E0 (1 cycle).
- **Throughput:** `in_ready_o` returns to 1 the cycle after the result is consumed. No same-cycle result-consume plus accept, so the minimum issue interval is 35 cycles for a normal op with an immediately ready consumer.
- **Backpressure:** `out_ready_i` low holds DONE indefinitely with `result_o` unchanged.
- **Outputs:** `in_ready_o` and `out_valid_o` are pure decodes of the state register, so there is no combinational path from any input.

## Structure
- **Package `ysyx_25040101_mdu_pkg`** holds:
  - funct3 localparams (`MDU_MUL` … `MDU_REMU`);
  - the state enum (IDLE/CALC/DONE);
  - `XLEN`.
- **Sub-module `ysyx_25040101_mdu_sign`** (natural, one only): combinational operand abs-value and sign-flag decode plus the final negate. Both the mul and div paths use it.
- **Top level:** FSM, counter, shared accumulator/remainder register and result register.

## Test plan
- **Multiply:**
  - mul 7 × 0xFFFFFFFD → 0xFFFFFFEB; `out_valid_o` high exactly 33 cycles after accept.
  - mulh 0x80000000 × 0x80000000 → 0x40000000.
  - mulhu 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - mulhsu 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- **Signed divide:** div 0xFFFFFFF9 / 2 → 0xFFFFFFFD; rem → 0xFFFFFFFF. divu 100 / 7 → 14; remu → 2.
- **Special cases, each with `out_valid_o` high one cycle after accept:**
  - divu 5 / 0 → 0xFFFFFFFF; remu 5 / 0 → 5.
  - div 0x80000000 / 0xFFFFFFFF → 0x80000000; rem → 0.
- **Backpressure:** hold `out_ready_i` = 0 for 10 cycles after result → `result_o` stable, `in_ready_o` = 0. Then `out_ready_i` = 1 → IDLE next cycle and `in_ready_o` = 1.
- **Abort:**
  - `flush_i` at CALC iteration 15 → IDLE next edge, no `out_valid_o`; a following mul 3 × 4 → 12.
  - `rst` in mid-CALC → all outputs back to their reset values at the next edge.
